// File: rtl/core_seq_ctrl.sv
// Core sequencer: steps IF/ID/EX/MEM/WB/TRAP, bounds bus waits with a timeout,
// latches the fetched instruction, flags access faults and counts retirements.
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins_rdata,
    input  logic        biu_ack,
    input  logic        biu_err,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        ill_ins,
    input  logic        env_call,
    input  logic        break_point,
    input  logic        ins_addr_mis,
    input  logic        addr_mis,
    input  logic        timer_int_acc,
    input  logic        ext_int_acc,
    input  logic        soft_int_acc,
    output logic [2:0]  statu,
    output logic        if_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] ins,
    output logic        ins_acc_fault,
    output logic        load_acc_fault,
    output logic [31:0] retire_cnt
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_WB   = 3'b011,
        S_TRAP = 3'b100,
        S_MEM  = 3'b101
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XLEN-1:0]   ins_q, ins_d;
    logic [XLEN-1:0]   retire_q, retire_d;
    logic              ins_fault_q, ins_fault_d;
    logic              load_fault_q, load_fault_d;
    logic              timeout_c;

    assign timeout_c      = (wait_q == WAIT_MAX);
    assign statu          = state_q;
    assign ins            = ins_q;
    assign retire_cnt     = retire_q;
    assign ins_acc_fault  = ins_fault_q;
    assign load_acc_fault = load_fault_q;

    // State, wait counter, instruction latch, fault flags and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IF;
            wait_q       <= '0;
            ins_q        <= '0;
            retire_q     <= '0;
            ins_fault_q  <= 1'b0;
            load_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            ins_q        <= ins_d;
            retire_q     <= retire_d;
            ins_fault_q  <= ins_fault_d;
            load_fault_q <= load_fault_d;
        end
    end

    // Next-state and request decode; wait counter restarts on every state change.
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        ins_d        = ins_q;
        retire_d     = retire_q;
        ins_fault_d  = ins_fault_q;
        load_fault_d = load_fault_q;
        if_req       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            S_IF: begin
                if (ins_addr_mis) begin
                    state_d = S_TRAP;
                end else begin
                    if_req = 1'b1;
                    if (biu_err) begin
                        ins_fault_d = 1'b1;
                        state_d     = S_TRAP;
                    end else if (biu_ack) begin
                        ins_d   = ins_rdata;
                        state_d = S_ID;
                    end else if (timeout_c) begin
                        ins_fault_d = 1'b1;
                        state_d     = S_TRAP;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_ID: begin
                state_d = (ill_ins | env_call | break_point) ? S_TRAP : S_EX;
            end
            S_EX: begin
                if ((dec_load | dec_store) & addr_mis) begin
                    state_d = S_TRAP;
                end else if (dec_load | dec_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_store;
                if (biu_err) begin
                    load_fault_d = 1'b1;
                    state_d      = S_TRAP;
                end else if (biu_ack) begin
                    state_d = S_WB;
                end else if (timeout_c) begin
                    load_fault_d = 1'b1;
                    state_d      = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retire_d = retire_q + XLEN'(1);
                state_d  = (timer_int_acc | ext_int_acc | soft_int_acc) ? S_TRAP : S_IF;
            end
            S_TRAP: begin
                ins_fault_d  = 1'b0;
                load_fault_d = 1'b0;
                state_d      = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        // Bus requests are held off for as long as reset is asserted.
        if (rst) begin
            if_req  = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized scoreboard bench for core_seq_ctrl: per-instruction scenarios are
// expanded into per-cycle expectations by a reference model and checked by a monitor.
module tb_core_seq_ctrl;

    localparam int unsigned TO = 4;
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_WB = 3'd3,
                           S_TRAP = 3'd4, S_MEM = 3'd5;
    localparam int END_ACK = 0, END_ERR = 1, END_BOTH = 2, END_TO = 3;

    logic        clk, rst;
    logic [31:0] ins_rdata;
    logic        biu_ack, biu_err, dec_load, dec_store;
    logic        ill_ins, env_call, break_point, ins_addr_mis, addr_mis;
    logic        timer_int_acc, ext_int_acc, soft_int_acc;
    logic [2:0]  statu;
    logic        if_req, mem_req, mem_we, ins_acc_fault, load_acc_fault;
    logic [31:0] ins, retire_cnt;

    core_seq_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ins_rdata(ins_rdata), .biu_ack(biu_ack), .biu_err(biu_err),
        .dec_load(dec_load), .dec_store(dec_store), .ill_ins(ill_ins), .env_call(env_call),
        .break_point(break_point), .ins_addr_mis(ins_addr_mis), .addr_mis(addr_mis),
        .timer_int_acc(timer_int_acc), .ext_int_acc(ext_int_acc), .soft_int_acc(soft_int_acc),
        .statu(statu), .if_req(if_req), .mem_req(mem_req), .mem_we(mem_we), .ins(ins),
        .ins_acc_fault(ins_acc_fault), .load_acc_fault(load_acc_fault), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic ack, err, ld, st, ill, env, bp, imis, amis, tint, eint, sint;
    } in_t;

    typedef struct {
        logic [2:0]  st;
        logic        ifr, mr, mw, fi, fl;
        logic [31:0] ins;
        logic [31:0] ret;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          fmis;
        int          fwait;
        int          fend;
        logic [31:0] word;
        int          exc;
        int          ls;
        bit          amis;
        int          mwait;
        int          mend;
        logic [2:0]  irq;
        bit          rst_mem;
    } scen_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errs = 0;
    int          cyc_no = 0;
    logic [31:0] m_ins, m_ret;

    function automatic void chk(string name, int cno, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cno, act, req);
        end
    endfunction

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("statu",          mon_e.cyc, 32'(statu),          32'(mon_e.st));
            chk("if_req",         mon_e.cyc, 32'(if_req),         32'(mon_e.ifr));
            chk("mem_req",        mon_e.cyc, 32'(mem_req),        32'(mon_e.mr));
            chk("mem_we",         mon_e.cyc, 32'(mem_we),         32'(mon_e.mw));
            chk("ins",            mon_e.cyc, ins,                 mon_e.ins);
            chk("ins_acc_fault",  mon_e.cyc, 32'(ins_acc_fault),  32'(mon_e.fi));
            chk("load_acc_fault", mon_e.cyc, 32'(load_acc_fault), 32'(mon_e.fl));
            chk("retire_cnt",     mon_e.cyc, retire_cnt,          mon_e.ret);
        end
    end

    function automatic exp_t mk(logic [2:0] st, logic ifr, logic mr, logic mw, logic fi, logic fl);
        exp_t e;
        e.st = st; e.ifr = ifr; e.mr = mr; e.mw = mw; e.fi = fi; e.fl = fl;
        e.ins = m_ins; e.ret = m_ret; e.cyc = cyc_no;
        return e;
    endfunction

    function automatic in_t noise();
        in_t in;
        in.rdata = $urandom;
        in.ack  = 1'($urandom); in.err  = 1'($urandom);
        in.ld   = 1'($urandom); in.st   = 1'($urandom);
        in.ill  = 1'($urandom); in.env  = 1'($urandom); in.bp = 1'($urandom);
        in.imis = 1'($urandom); in.amis = 1'($urandom);
        in.tint = 1'($urandom); in.eint = 1'($urandom); in.sint = 1'($urandom);
        return in;
    endfunction

    task automatic cyc(input in_t in, input exp_t e);
        ins_rdata = in.rdata; biu_ack = in.ack; biu_err = in.err;
        dec_load = in.ld; dec_store = in.st; ill_ins = in.ill; env_call = in.env;
        break_point = in.bp; ins_addr_mis = in.imis; addr_mis = in.amis;
        timer_int_acc = in.tint; ext_int_acc = in.eint; soft_int_acc = in.sint;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        m_ins = '0;
        m_ret = '0;
        for (int k = 0; k < n; k++) cyc(noise(), mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
    endtask

    task automatic trap(input logic fi, input logic fl);
        cyc(noise(), mk(S_TRAP, 1'b0, 1'b0, 1'b0, fi, fl));
    endtask

    // A bus transfer in IF or MEM: waits, then ack/err, or a timeout after TO+1 idle cycles.
    task automatic bus_phase(input logic is_mem, input scen_t s, output logic ok);
        in_t        in;
        int         nw = is_mem ? s.mwait : s.fwait;
        int         en = is_mem ? s.mend : s.fend;
        logic [2:0] st = is_mem ? S_MEM : S_IF;
        logic       mw = is_mem && (s.ls == 2);
        ok = 1'b0;
        if (en == END_TO) nw = TO + 1;
        for (int k = 0; k < nw; k++) begin
            if (is_mem && s.rst_mem && k == 1) begin
                do_reset(2);
                return;
            end
            in = noise();
            if (is_mem) begin in.ld = (s.ls == 1); in.st = (s.ls == 2); end
            else in.imis = 1'b0;
            in.ack = 1'b0; in.err = 1'b0;
            cyc(in, mk(st, !is_mem, is_mem, mw, 1'b0, 1'b0));
        end
        if (en == END_TO) begin
            trap(!is_mem, is_mem);
            return;
        end
        in = noise();
        if (is_mem) begin in.ld = (s.ls == 1); in.st = (s.ls == 2); end
        else in.imis = 1'b0;
        in.rdata = s.word;
        in.ack = (en != END_ERR);
        in.err = (en != END_ACK);
        cyc(in, mk(st, !is_mem, is_mem, mw, 1'b0, 1'b0));
        if (in.err) begin
            trap(!is_mem, is_mem);
            return;
        end
        if (!is_mem) m_ins = s.word;
        ok = 1'b1;
    endtask

    // Reference model: one instruction from fetch to retirement or trap.
    task automatic run_instr(input scen_t s);
        in_t  in;
        logic ok;
        if (s.fmis) begin
            in = noise();
            in.imis = 1'b1;
            cyc(in, mk(S_IF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            trap(1'b0, 1'b0);
            return;
        end
        bus_phase(1'b0, s, ok);
        if (!ok) return;
        in = noise();
        in.ill = (s.exc == 1); in.env = (s.exc == 2); in.bp = (s.exc == 3);
        cyc(in, mk(S_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (s.exc != 0) begin
            trap(1'b0, 1'b0);
            return;
        end
        in = noise();
        in.ld = (s.ls == 1); in.st = (s.ls == 2); in.amis = s.amis;
        cyc(in, mk(S_EX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (s.ls != 0) begin
            if (s.amis) begin
                trap(1'b0, 1'b0);
                return;
            end
            bus_phase(1'b1, s, ok);
            if (!ok) return;
        end
        in = noise();
        {in.tint, in.eint, in.sint} = s.irq;
        cyc(in, mk(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_ret = m_ret + 32'd1;
        if (s.irq != 3'b000) trap(1'b0, 1'b0);
    endtask

    function automatic scen_t base();
        scen_t s;
        s.fmis = 1'b0; s.fwait = 0; s.fend = END_ACK; s.word = $urandom;
        s.exc = 0; s.ls = 0; s.amis = 1'b0; s.mwait = 0; s.mend = END_ACK;
        s.irq = 3'b000; s.rst_mem = 1'b0;
        return s;
    endfunction

    function automatic int rnd_end();
        int r = int'($urandom_range(0, 9));
        if (r < 6) return END_ACK;
        if (r == 6) return END_ERR;
        if (r == 7) return END_BOTH;
        return END_TO;
    endfunction

    function automatic scen_t rnd();
        scen_t s = base();
        s.fmis  = ($urandom_range(0, 15) == 0);
        s.fwait = int'($urandom_range(0, TO));
        s.fend  = rnd_end();
        s.exc   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
        s.ls    = int'($urandom_range(0, 2));
        s.amis  = ($urandom_range(0, 7) == 0);
        s.mwait = int'($urandom_range(0, TO));
        s.mend  = rnd_end();
        s.irq   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        return s;
    endfunction

    scen_t s;

    initial begin
        rst = 1'b1;
        {ins_rdata, biu_ack, biu_err, dec_load, dec_store} = '0;
        {ill_ins, env_call, break_point, ins_addr_mis, addr_mis} = '0;
        {timer_int_acc, ext_int_acc, soft_int_acc} = '0;
        @(posedge clk);
        #1;
        do_reset(3);

        // ALU op, fetch acked after two wait cycles.
        s = base(); s.fwait = 2; run_instr(s);
        // Load acked on the fourth MEM cycle.
        s = base(); s.ls = 1; s.mwait = 3; run_instr(s);
        // Load never acked: timeout fault.
        s = base(); s.ls = 1; s.mend = END_TO; run_instr(s);
        // Illegal instruction.
        s = base(); s.exc = 1; run_instr(s);
        // External interrupt at WB.
        s = base(); s.irq = 3'b010; run_instr(s);
        // Ack and err together in IF: err wins, ins kept.
        s = base(); s.fwait = 1; s.fend = END_BOTH; run_instr(s);
        // Retire counter wrap from all-ones.
        force dut.retire_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        fork
            begin
                @(posedge clk);
                #2;
                release dut.retire_q;
            end
        join_none
        s = base(); s.fwait = 2; run_instr(s);
        // Further corners.
        s = base(); s.fmis = 1'b1; run_instr(s);
        s = base(); s.fwait = TO; run_instr(s);
        s = base(); s.fend = END_TO; run_instr(s);
        s = base(); s.ls = 2; s.mwait = TO; run_instr(s);
        s = base(); s.ls = 2; s.mwait = 1; s.mend = END_BOTH; run_instr(s);
        s = base(); s.ls = 2; s.mwait = 2; s.mend = END_ERR; run_instr(s);
        s = base(); s.ls = 1; s.amis = 1'b1; run_instr(s);
        s = base(); s.exc = 3; run_instr(s);
        s = base(); s.ls = 1; s.mwait = 3; s.rst_mem = 1'b1; run_instr(s);
        s = base(); s.fwait = 1; run_instr(s);

        for (int n = 0; n < 300; n++) run_instr(rnd());

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_errs++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
